// File: rtl/axil_bram_slave.sv
// axil_bram_slave: AXI4-Lite slave fronting a byte-writable block RAM.
//
// AW and W are captured independently into one-entry holding registers. A single FSM
// serialises accesses (one transaction in flight) and arbitrates fairly between a pending
// write and an incoming read using a priority bit that flips after every grant.
//
// Parameters:
//   DATA_W      data width (32 or 64)
//   ADDR_W      AXI byte-address width
//   BRAM_DEPTH  memory depth in words
//   BRAM_ADDR_W word-index width
//   BASE_ADDR   byte address of word 0
//   RD_LAT      BRAM read latency, 1 or 2
//
// Ports:
//   aclk_i, areset_i                 clock, synchronous active-high reset
//   aw_valid_i/aw_ready_o/aw_addr_i  write-address channel
//   w_valid_i/w_ready_o/w_data_i/w_strb_i  write-data channel
//   b_valid_o/b_ready_i/b_resp_o     write-response channel
//   ar_valid_i/ar_ready_o/ar_addr_i  read-address channel
//   r_valid_o/r_ready_i/r_data_o/r_resp_o  read-data channel
//
// Build option: define AXIL_BRAM_RANGE_CHECK_EN to answer out-of-range accesses with SLVERR
// (writes dropped, read data zero). Undefined, the word index is truncated (aliasing).

module axil_bram_slave #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       BRAM_DEPTH  = 1024,
    parameter int unsigned       BRAM_ADDR_W = $clog2(BRAM_DEPTH),
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       RD_LAT      = 1
) (
    input  logic                  aclk_i,
    input  logic                  areset_i,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ADDR_W-1:0]     aw_addr_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic [DATA_W-1:0]     w_data_i,
    input  logic [DATA_W/8-1:0]   w_strb_i,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [1:0]            b_resp_o,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ADDR_W-1:0]     ar_addr_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_W-1:0]     r_data_o,
    output logic [1:0]            r_resp_o
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned OFF_W    = $clog2(STRB_W);
    localparam logic [1:0]  RespOkay = 2'b00;
    localparam logic [1:0]  RespErr  = 2'b10;
    localparam logic        PrioWr   = 1'b0;
    localparam logic        PrioRd   = 1'b1;
    localparam logic        LatLast  = (RD_LAT == 2);

    typedef enum logic [2:0] {StIdle, StWrite, StWresp, StRead, StRresp} state_e;

    state_e              state_q, state_d;
    logic                prio_q, prio_d;
    logic                lat_cnt_q, lat_cnt_d;
    logic                en_q;          // holds readies low for one cycle after reset
    logic                aw_held_q, w_held_q;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic [BRAM_ADDR_W-1:0] rd_idx_q;
    logic                rd_err_q;
    logic [1:0]          b_resp_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   rd_pipe;
    logic [DATA_W-1:0]   mem_q [BRAM_DEPTH];

    logic                write_pending, read_ok, aw_hs, w_hs, ar_hs, wr_grant;
    logic [ADDR_W-1:0]   wr_word, rd_word;
    logic                wr_err, rd_err;
    logic                unused_bits;

    // Address decode: word index relative to BASE_ADDR, byte offset dropped.
    assign wr_word = (aw_addr_q - BASE_ADDR) >> OFF_W;
    assign rd_word = (ar_addr_i - BASE_ADDR) >> OFF_W;

`ifdef AXIL_BRAM_RANGE_CHECK_EN
    localparam logic [ADDR_W-1:0] DepthW = ADDR_W'(BRAM_DEPTH);
    assign wr_err = (aw_addr_q < BASE_ADDR) || (wr_word >= DepthW);
    assign rd_err = (ar_addr_i < BASE_ADDR) || (rd_word >= DepthW);
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    assign unused_bits = ^{wr_word[ADDR_W-1:BRAM_ADDR_W], rd_word[ADDR_W-1:BRAM_ADDR_W]};

    // Handshakes and arbitration. Grant and AR handshake are mutually exclusive.
    assign write_pending = aw_held_q & w_held_q;
    assign read_ok       = !write_pending || (prio_q == PrioRd);
    assign aw_ready_o    = en_q && !aw_held_q;
    assign w_ready_o     = en_q && !w_held_q;
    assign ar_ready_o    = en_q && (state_q == StIdle) && read_ok;
    assign aw_hs         = aw_valid_i && aw_ready_o;
    assign w_hs          = w_valid_i && w_ready_o;
    assign ar_hs         = ar_valid_i && ar_ready_o;
    assign wr_grant      = (state_q == StIdle) && write_pending &&
                           (!ar_valid_i || (prio_q == PrioWr));

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            StIdle: begin
                if (wr_grant) begin
                    state_d = StWrite;
                    prio_d  = PrioRd;
                end else if (ar_hs) begin
                    state_d   = StRead;
                    prio_d    = PrioWr;
                    lat_cnt_d = 1'b0;
                end
            end
            StWrite: state_d = StWresp;
            StWresp: if (b_ready_i) state_d = StIdle;
            StRead: begin
                if (lat_cnt_q == LatLast) state_d = StRresp;
                else                      lat_cnt_d = 1'b1;
            end
            StRresp: if (r_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            state_q   <= StIdle;
            prio_q    <= PrioWr;
            lat_cnt_q <= 1'b0;
            en_q      <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            rd_idx_q  <= '0;
            rd_err_q  <= 1'b0;
            b_resp_q  <= RespOkay;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            lat_cnt_q <= lat_cnt_d;
            en_q      <= 1'b1;
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= aw_addr_i;
            end else if (wr_grant) begin
                aw_held_q <= 1'b0;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= w_data_i;
                w_strb_q <= w_strb_i;
            end else if (wr_grant) begin
                w_held_q <= 1'b0;
            end
            if (ar_hs) begin
                rd_idx_q <= rd_word[BRAM_ADDR_W-1:0];
                rd_err_q <= rd_err;
            end
            if (state_q == StWrite) b_resp_q <= wr_err ? RespErr : RespOkay;
        end
    end

    // Block RAM: not reset. Held AW/W payload is still intact during StWrite because a
    // freshly captured entry only lands at the end of that cycle.
    always_ff @(posedge aclk_i) begin
        if (state_q == StWrite && !wr_err) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (w_strb_q[i]) mem_q[aw_addr_q[OFF_W +: BRAM_ADDR_W] - BASE_ADDR[OFF_W +: BRAM_ADDR_W]][8*i +: 8] <= w_data_q[8*i +: 8];
            end
        end
        rd_data_q <= mem_q[rd_idx_q];
    end

    // Read data stays stable through StRresp: rd_idx_q is frozen and no write can occur.
    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rd_data2_q;
        always_ff @(posedge aclk_i) rd_data2_q <= rd_data_q;
        assign rd_pipe = rd_data2_q;
    end else begin : g_lat1
        assign rd_pipe = rd_data_q;
    end

    assign b_valid_o = (state_q == StWresp);
    assign b_resp_o  = b_resp_q;
    assign r_valid_o = (state_q == StRresp);
    assign r_resp_o  = (r_valid_o && rd_err_q) ? RespErr : RespOkay;
    assign r_data_o  = (r_valid_o && !rd_err_q) ? rd_pipe : '0;

endmodule

// File: tb/tb_axil_bram_slave.sv
// Self-checking bench for axil_bram_slave. Two instances: dut0 (RD_LAT=1, BASE_ADDR=0)
// and dut1 (RD_LAT=2, BASE_ADDR=0x1000). Expectations follow the AXIL_BRAM_RANGE_CHECK_EN
// build option when it is defined.

module tb_axil_bram_slave;

`ifdef AXIL_BRAM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    logic        aw_valid [2], aw_ready [2], w_valid [2], w_ready [2], b_valid [2], b_ready [2];
    logic        ar_valid [2], ar_ready [2], r_valid [2], r_ready [2];
    logic [31:0] aw_addr [2], w_data [2], ar_addr [2], r_data [2];
    logic [3:0]  w_strb [2];
    logic [1:0]  b_resp [2], r_resp [2];

    axil_bram_slave #(.RD_LAT(1), .BASE_ADDR(32'h0)) dut0 (
        .aclk_i(clk), .areset_i(areset),
        .aw_valid_i(aw_valid[0]), .aw_ready_o(aw_ready[0]), .aw_addr_i(aw_addr[0]),
        .w_valid_i(w_valid[0]), .w_ready_o(w_ready[0]), .w_data_i(w_data[0]),
        .w_strb_i(w_strb[0]), .b_valid_o(b_valid[0]), .b_ready_i(b_ready[0]),
        .b_resp_o(b_resp[0]), .ar_valid_i(ar_valid[0]), .ar_ready_o(ar_ready[0]),
        .ar_addr_i(ar_addr[0]), .r_valid_o(r_valid[0]), .r_ready_i(r_ready[0]),
        .r_data_o(r_data[0]), .r_resp_o(r_resp[0])
    );

    axil_bram_slave #(.RD_LAT(2), .BASE_ADDR(32'h1000)) dut1 (
        .aclk_i(clk), .areset_i(areset),
        .aw_valid_i(aw_valid[1]), .aw_ready_o(aw_ready[1]), .aw_addr_i(aw_addr[1]),
        .w_valid_i(w_valid[1]), .w_ready_o(w_ready[1]), .w_data_i(w_data[1]),
        .w_strb_i(w_strb[1]), .b_valid_o(b_valid[1]), .b_ready_i(b_ready[1]),
        .b_resp_o(b_resp[1]), .ar_valid_i(ar_valid[1]), .ar_ready_o(ar_ready[1]),
        .ar_addr_i(ar_addr[1]), .r_valid_o(r_valid[1]), .r_ready_i(r_ready[1]),
        .r_data_o(r_data[1]), .r_resp_o(r_resp[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write; lat = cycles from the last AW/W handshake cycle to B_VALID.
    task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp, output int lat);
        int   guard = 0;
        logic awf, wf;
        aw_valid[k] = 1'b1; aw_addr[k] = a;
        w_valid[k] = 1'b1; w_data[k] = d; w_strb[k] = s;
        b_ready[k] = 1'b1;
        while ((aw_valid[k] || w_valid[k]) && guard < 20) begin
            awf = aw_valid[k] && aw_ready[k];
            wf  = w_valid[k] && w_ready[k];
            tick();
            guard++;
            if (awf) aw_valid[k] = 1'b0;
            if (wf)  w_valid[k] = 1'b0;
        end
        lat = 1;
        while (!b_valid[k] && lat < 20) begin
            tick();
            lat++;
        end
        resp = b_resp[k];
        tick();
        b_ready[k] = 1'b0; aw_valid[k] = 1'b0; w_valid[k] = 1'b0;
    endtask

    // Full read; lat = cycles from the AR handshake cycle to R_VALID.
    task automatic do_read(input int k, input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        int guard = 0;
        ar_valid[k] = 1'b1; ar_addr[k] = a; r_ready[k] = 1'b1;
        while (!ar_ready[k] && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        ar_valid[k] = 1'b0;
        lat = 1;
        while (!r_valid[k] && lat < 20) begin
            tick();
            lat++;
        end
        data = r_data[k];
        resp = r_resp[k];
        tick();
        r_ready[k] = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        int          k;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        logic [3:0]  strb;
        logic [1:0]  resp;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [31:0] rd, exp_d;
        logic [1:0]  resp;
        logic [5:0]  ord;
        logic        awf, wf;
        int          lat, nbeats, guard;

        vecs[0]  = '{1, 0, 32'h10,   32'hDEADBEEF, 4'hF, 2'b00, 3};
        vecs[1]  = '{0, 0, 32'h10,   32'hDEADBEEF, 4'h0, 2'b00, 2};
        vecs[2]  = '{1, 0, 32'h20,   32'h11223344, 4'hF, 2'b00, 3};
        vecs[3]  = '{1, 0, 32'h22,   32'hAABBCCDD, 4'h9, 2'b00, 3};
        vecs[4]  = '{0, 0, 32'h23,   32'hAA2233DD, 4'h0, 2'b00, 2};
        vecs[5]  = '{1, 0, 32'h20,   32'hFFFFFFFF, 4'h0, 2'b00, 3};
        vecs[6]  = '{0, 0, 32'h20,   32'hAA2233DD, 4'h0, 2'b00, 2};
        vecs[7]  = '{1, 1, 32'h1000, 32'hCAFEF00D, 4'hF, 2'b00, 3};
        vecs[8]  = '{0, 1, 32'h1000, 32'hCAFEF00D, 4'h0, 2'b00, 3};
        vecs[9]  = '{1, 1, 32'h1FFC, 32'h0BADBEEF, 4'hF, 2'b00, 3};
        vecs[10] = '{0, 1, 32'h1FFC, 32'h0BADBEEF, 4'h0, 2'b00, 3};
        vecs[11] = '{1, 1, 32'h2000, 32'h12345678, 4'hF, RC ? 2'b10 : 2'b00, 3};
        vecs[12] = '{0, 1, 32'h1000, RC ? 32'hCAFEF00D : 32'h12345678, 4'h0, 2'b00, 3};
        vecs[13] = '{0, 1, 32'h0FFC, RC ? 32'h0 : 32'h0BADBEEF, 4'h0,
                     RC ? 2'b10 : 2'b00, 3};

        for (int k = 0; k < 2; k++) begin
            aw_valid[k] = 0; aw_addr[k] = 0; w_valid[k] = 0; w_data[k] = 0; w_strb[k] = 0;
            b_ready[k] = 0; ar_valid[k] = 0; ar_addr[k] = 0; r_ready[k] = 0;
        end

        // Reset: all outputs low during and one cycle after, readies rise next.
        areset = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            check("rst_aw_ready", 32'(aw_ready[k]), 0);
            check("rst_w_ready", 32'(w_ready[k]), 0);
            check("rst_ar_ready", 32'(ar_ready[k]), 0);
            check("rst_b_valid", 32'(b_valid[k]), 0);
            check("rst_r_valid", 32'(r_valid[k]), 0);
            check("rst_b_resp", 32'(b_resp[k]), 0);
            check("rst_r_resp", 32'(r_resp[k]), 0);
            check("rst_r_data", r_data[k], 0);
        end
        areset = 1'b0;
        check("post_rst_aw_ready_low", 32'(aw_ready[0]), 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            check("post_rst_aw_ready", 32'(aw_ready[k]), 1);
            check("post_rst_w_ready", 32'(w_ready[k]), 1);
            check("post_rst_ar_ready", 32'(ar_ready[k]), 1);
        end

        // Table of directed transactions.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].k, vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
                check($sformatf("vec%0d_b_resp", i), 32'(resp), 32'(vecs[i].resp));
                check($sformatf("vec%0d_b_lat", i), lat, vecs[i].lat);
            end else begin
                do_read(vecs[i].k, vecs[i].addr, rd, resp, lat);
                check($sformatf("vec%0d_r_data", i), rd, vecs[i].data);
                check($sformatf("vec%0d_r_resp", i), 32'(resp), 32'(vecs[i].resp));
                check($sformatf("vec%0d_r_lat", i), lat, vecs[i].lat);
            end
        end

        // W arrives three cycles before AW; partial-strobe merge.
        w_valid[0] = 1'b1; w_data[0] = 32'h00AA0000; w_strb[0] = 4'b0100;
        tick();
        w_valid[0] = 1'b0;
        check("w_held_blocks_w_ready", 32'(w_ready[0]), 0);
        check("w_only_no_b", 32'(b_valid[0]), 0);
        tick();
        tick();
        aw_valid[0] = 1'b1; aw_addr[0] = 32'h10; b_ready[0] = 1'b1;
        tick();
        aw_valid[0] = 1'b0;
        lat = 1;
        while (!b_valid[0] && lat < 20) begin
            tick();
            lat++;
        end
        check("w_first_b_lat", lat, 3);
        check("w_first_b_resp", 32'(b_resp[0]), 0);
        tick();
        b_ready[0] = 1'b0;
        do_read(0, 32'h10, rd, resp, lat);
        check("w_first_readback", rd, 32'hDEAABEEF);

        // Arbitration after reset: write first, then strict alternation.
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        tick();
        tick();
        aw_valid[0] = 1'b1; aw_addr[0] = 32'h40;
        w_valid[0] = 1'b1; w_data[0] = 32'h40404040; w_strb[0] = 4'hF;
        tick();
        aw_valid[0] = 1'b0; w_valid[0] = 1'b0;
        ar_valid[0] = 1'b1; ar_addr[0] = 32'h10;
        check("arb_write_first_ar_blocked", 32'(ar_ready[0]), 0);
        aw_valid[0] = 1'b1; aw_addr[0] = 32'h44;
        w_valid[0] = 1'b1; w_data[0] = 32'h44444444;
        b_ready[0] = 1'b1; r_ready[0] = 1'b1;
        ord = '0; nbeats = 0; rd = '0;
        for (int c = 0; c < 40 && nbeats < 3; c++) begin
            awf = aw_valid[0] && aw_ready[0];
            wf  = w_valid[0] && w_ready[0];
            if (ar_valid[0] && ar_ready[0]) begin
                tick();
                ar_valid[0] = 1'b0;
            end else begin
                if (b_valid[0]) begin ord = {ord[3:0], 2'd1}; nbeats++; end
                if (r_valid[0]) begin ord = {ord[3:0], 2'd2}; nbeats++; rd = r_data[0]; end
                tick();
            end
            if (awf) aw_valid[0] = 1'b0;
            if (wf)  w_valid[0] = 1'b0;
        end
        b_ready[0] = 1'b0; r_ready[0] = 1'b0;
        aw_valid[0] = 1'b0; w_valid[0] = 1'b0; ar_valid[0] = 1'b0;
        check("arb_order_w_r_w", 32'(ord), 32'(6'b011001));
        check("arb_read_data", rd, 32'hDEAABEEF);
        do_read(0, 32'h40, rd, resp, lat);
        check("arb_wr1_data", rd, 32'h40404040);
        do_read(0, 32'h44, rd, resp, lat);
        check("arb_wr2_data", rd, 32'h44444444);

        // RD_LAT=2 with R_READY held low for five cycles.
        exp_d = RC ? 32'hCAFEF00D : 32'h12345678;
        ar_valid[1] = 1'b1; ar_addr[1] = 32'h1000; r_ready[1] = 1'b0;
        guard = 0;
        while (!ar_ready[1] && guard < 20) begin tick(); guard++; end
        tick();
        ar_valid[1] = 1'b0;
        lat = 1;
        while (!r_valid[1] && lat < 20) begin tick(); lat++; end
        check("stall_r_lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            check("stall_r_valid", 32'(r_valid[1]), 1);
            check("stall_r_data", r_data[1], exp_d);
            tick();
        end
        r_ready[1] = 1'b1;
        check("stall_r_valid_at_ready", 32'(r_valid[1]), 1);
        tick();
        r_ready[1] = 1'b0;
        check("stall_r_drop", 32'(r_valid[1]), 0);

        // B_READY held low for five cycles.
        aw_valid[1] = 1'b1; aw_addr[1] = 32'h1004;
        w_valid[1] = 1'b1; w_data[1] = 32'h5A5A5A5A; w_strb[1] = 4'hF;
        b_ready[1] = 1'b0;
        tick();
        aw_valid[1] = 1'b0; w_valid[1] = 1'b0;
        lat = 1;
        while (!b_valid[1] && lat < 20) begin tick(); lat++; end
        check("stall_b_lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            check("stall_b_valid", 32'(b_valid[1]), 1);
            check("stall_b_resp", 32'(b_resp[1]), 0);
            tick();
        end
        b_ready[1] = 1'b1;
        tick();
        b_ready[1] = 1'b0;
        check("stall_b_drop", 32'(b_valid[1]), 0);
        do_read(1, 32'h1004, rd, resp, lat);
        check("stall_b_readback", rd, 32'h5A5A5A5A);

        // Reset pulse while in RRESP with R_READY low.
        ar_valid[0] = 1'b1; ar_addr[0] = 32'h10; r_ready[0] = 1'b0;
        guard = 0;
        while (!ar_ready[0] && guard < 20) begin tick(); guard++; end
        tick();
        ar_valid[0] = 1'b0;
        guard = 0;
        while (!r_valid[0] && guard < 20) begin tick(); guard++; end
        check("rst_mid_r_valid_before", 32'(r_valid[0]), 1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("rst_mid_r_valid", 32'(r_valid[0]), 0);
        check("rst_mid_r_data", r_data[0], 0);
        check("rst_mid_aw_ready_low", 32'(aw_ready[0]), 0);
        check("rst_mid_ar_ready_low", 32'(ar_ready[0]), 0);
        tick();
        check("rst_mid_aw_ready", 32'(aw_ready[0]), 1);
        check("rst_mid_w_ready", 32'(w_ready[0]), 1);
        check("rst_mid_ar_ready", 32'(ar_ready[0]), 1);
        check("rst_mid_no_r", 32'(r_valid[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
